// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions for the integer issue path.
// Contents: major opcodes, funct3 operation codes, the funct7 alternate
// encoding, the R/I-type field layout, and the issue sequencer state type.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] FUNCT7_ALT = 7'h20;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SRL  = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } funct3_e;

    // R-type field layout; for I-type the funct7/rs2 fields hold imm[11:0].
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        funct3_e    funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rtype_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

endpackage

// File: rtl/imm_gen.sv
// I-type immediate sign extension.
// Ports: imm12 - instruction bits [31:20]; imm_i - sign-extended immediate.
module imm_gen #(
    parameter int unsigned XLEN = 32
) (
    input  logic [11:0]     imm12,
    output logic [XLEN-1:0] imm_i
);

    assign imm_i = {{(XLEN - 12){imm12[11]}}, imm12};

endmodule

// File: rtl/alu_issue.sv
// Single-issue sequencer for RV32I OP / OP-IMM instructions.
// Accepts one instruction, reads rs1/rs2 from the register file, presents
// operands and function codes to the external clocked ALU, waits ALU_LAT
// cycles and writes the result back to rd.
// Ports:
//   instr_valid/instr/instr_ready - instruction handshake from fetch
//   rf_raddr1/2, rf_rdata1/2      - combinational register file read
//   rf_we/rf_waddr/rf_wdata       - write-back, valid during the WB cycle
//   alu_rs1/rs2/funct3/funct7     - ALU request, held through EXEC and WB
//   alu_rd/alu_z                  - ALU result and zero flag
//   done/zero/illegal             - retire pulse, captured zero, bad-opcode pulse
module alu_issue
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_rs2,
    output logic [2:0]      alu_funct3,
    output logic [6:0]      alu_funct7,
    input  logic [XLEN-1:0] alu_rd,
    input  logic            alu_z,
    output logic            done,
    output logic            zero,
    output logic            illegal
);

    localparam int unsigned      CNT_W    = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);

    rtype_t           iw;
    state_e           state_q, state_d;
    logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  imm_i;
    logic             accept, legal;

    logic             instr_ready_d, rf_we_d, done_d, zero_d, illegal_d;
    logic [4:0]       rf_waddr_d;
    logic [XLEN-1:0]  alu_rs1_d, alu_rs2_d;
    logic [2:0]       alu_funct3_d;
    logic [6:0]       alu_funct7_d;

    assign iw     = rtype_t'(instr);
    assign accept = instr_valid && instr_ready;
    assign legal  = (iw.opcode == OPC_OP) || (iw.opcode == OPC_OP_IMM);

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .imm12 (instr[31:20]),
        .imm_i (imm_i)
    );

    // Read addresses follow the offered word while idle so operands are
    // ready at the accept edge; afterwards they track the latched word.
    assign rf_raddr1 = (state_q == ST_IDLE) ? iw.rs1 : rs1_q;
    assign rf_raddr2 = (state_q == ST_IDLE) ? iw.rs2 : rs2_q;

    // The ALU result only becomes valid in the WB cycle, so write data is
    // forwarded straight from the ALU's output register during WB.
    assign rf_wdata = (state_q == ST_WB) ? alu_rd : '0;

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        rd_d          = rd_q;
        cnt_d         = cnt_q;
        instr_ready_d = instr_ready;
        rf_we_d       = 1'b0;
        rf_waddr_d    = rf_waddr;
        done_d        = 1'b0;
        zero_d        = zero;
        illegal_d     = 1'b0;
        alu_rs1_d     = alu_rs1;
        alu_rs2_d     = alu_rs2;
        alu_funct3_d  = alu_funct3;
        alu_funct7_d  = alu_funct7;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (legal) begin
                        state_d       = ST_EXEC;
                        rs1_d         = iw.rs1;
                        rs2_d         = iw.rs2;
                        rd_d          = iw.rd;
                        cnt_d         = '0;
                        instr_ready_d = 1'b0;
                        alu_rs1_d     = rf_rdata1;
                        alu_funct3_d  = iw.funct3;
                        if (iw.opcode == OPC_OP) begin
                            alu_rs2_d    = rf_rdata2;
                            alu_funct7_d = iw.funct7;
                        end else begin
                            // Only SRLI/SRAI carry a meaningful funct7; ADDI must never become SUB.
                            alu_rs2_d    = imm_i;
                            alu_funct7_d = (iw.funct3 == F3_SRL) ? iw.funct7 : 7'h00;
                        end
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end

            ST_EXEC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d    = ST_WB;
                    rf_we_d    = (rd_q != 5'd0);
                    rf_waddr_d = rd_q;
                    done_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_WB: begin
                state_d       = ST_IDLE;
                instr_ready_d = 1'b1;
                zero_d        = alu_z;
            end

            default: begin
                state_d       = ST_IDLE;
                instr_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            instr_ready <= 1'b1;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            done        <= 1'b0;
            zero        <= 1'b0;
            illegal     <= 1'b0;
            alu_rs1     <= '0;
            alu_rs2     <= '0;
            alu_funct3  <= '0;
            alu_funct7  <= '0;
        end else begin
            state_q     <= state_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            instr_ready <= instr_ready_d;
            rf_we       <= rf_we_d;
            rf_waddr    <= rf_waddr_d;
            done        <= done_d;
            zero        <= zero_d;
            illegal     <= illegal_d;
            alu_rs1     <= alu_rs1_d;
            alu_rs2     <= alu_rs2_d;
            alu_funct3  <= alu_funct3_d;
            alu_funct7  <= alu_funct7_d;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural register file and a
// one-cycle clocked ALU. Expected values are hand-computed constants.
module tb_alu_issue;

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] IMM = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;

    localparam logic [31:0] W_ADD  = {7'h00, 5'd2, 5'd1, 3'b000, 5'd3, OP};
    localparam logic [31:0] W_SUB  = {7'h20, 5'd2, 5'd1, 3'b000, 5'd5, OP};
    localparam logic [31:0] W_ADDI = {12'hFFF, 5'd1, 3'b000, 5'd4, IMM};
    localparam logic [31:0] W_SRAI = {7'h20, 5'd3, 5'd1, 3'b101, 5'd6, IMM};
    localparam logic [31:0] W_XOR0 = {7'h00, 5'd2, 5'd1, 3'b100, 5'd0, OP};
    localparam logic [31:0] W_OR9  = {7'h00, 5'd2, 5'd1, 3'b110, 5'd9, OP};
    localparam logic [31:0] W_SUB7 = {7'h20, 5'd2, 5'd1, 3'b000, 5'd7, OP};
    localparam logic [31:0] W_LW   = {12'd4, 5'd1, 3'b010, 5'd7, LD};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] alu_rs1, alu_rs2;
    logic [2:0]  alu_funct3;
    logic [6:0]  alu_funct7;
    logic [31:0] alu_rd;
    logic        alu_z;
    logic        done, zero, illegal;

    logic [31:0] rf [32];
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    // Reference ALU: registers its result one cycle after the request.
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3, input logic [6:0] f7);
        case (f3)
            3'b000:  return f7[5] ? a - b : a + b;
            3'b001:  return a << b[4:0];
            3'b010:  return {31'b0, $signed(a) < $signed(b)};
            3'b011:  return {31'b0, a < b};
            3'b100:  return a ^ b;
            3'b101:  return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    always @(posedge clk) begin
        alu_rd <= alu_f(alu_rs1, alu_rs2, alu_funct3, alu_funct7);
        alu_z  <= (alu_f(alu_rs1, alu_rs2, alu_funct3, alu_funct7) == 32'd0);
    end

    alu_issue #(.XLEN(32), .ALU_LAT(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .alu_rs1     (alu_rs1),
        .alu_rs2     (alu_rs2),
        .alu_funct3  (alu_funct3),
        .alu_funct7  (alu_funct7),
        .alu_rd      (alu_rd),
        .alu_z       (alu_z),
        .done        (done),
        .zero        (zero),
        .illegal     (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction and follow it through EXEC, WB and back to IDLE.
    task automatic issue(input string tag, input logic [31:0] w,
                         input logic [31:0] e_rs1, input logic [31:0] e_rs2,
                         input logic [2:0] e_f3, input logic [6:0] e_f7,
                         input logic e_we, input logic [4:0] e_wa,
                         input logic [31:0] e_wd, input logic e_z);
        instr       = w;
        instr_valid = 1'b1;
        #1;
        chk({tag, ".raddr1"}, 32'(rf_raddr1), 32'(w[19:15]));
        step();
        instr_valid = 1'b0;
        instr       = 32'h0;
        #1;
        chk({tag, ".exec_ready"}, 32'(instr_ready), 32'd0);
        chk({tag, ".exec_raddr1"}, 32'(rf_raddr1), 32'(w[19:15]));
        chk({tag, ".rs1"}, alu_rs1, e_rs1);
        chk({tag, ".rs2"}, alu_rs2, e_rs2);
        chk({tag, ".funct3"}, 32'(alu_funct3), 32'(e_f3));
        chk({tag, ".funct7"}, 32'(alu_funct7), 32'(e_f7));
        chk({tag, ".exec_we"}, 32'(rf_we), 32'd0);
        chk({tag, ".exec_done"}, 32'(done), 32'd0);
        step();
        chk({tag, ".wb_done"}, 32'(done), 32'd1);
        chk({tag, ".wb_we"}, 32'(rf_we), 32'(e_we));
        chk({tag, ".wb_waddr"}, 32'(rf_waddr), 32'(e_wa));
        chk({tag, ".wb_wdata"}, rf_wdata, e_wd);
        chk({tag, ".wb_ready"}, 32'(instr_ready), 32'd0);
        step();
        chk({tag, ".idle_done"}, 32'(done), 32'd0);
        chk({tag, ".idle_we"}, 32'(rf_we), 32'd0);
        chk({tag, ".idle_ready"}, 32'(instr_ready), 32'd1);
        chk({tag, ".zero"}, 32'(zero), 32'(e_z));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 32'h0;
        #12;
        chk("rst.ready", 32'(instr_ready), 32'd1);
        chk("rst.we", 32'(rf_we), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.illegal", 32'(illegal), 32'd0);
        chk("rst.zero", 32'(zero), 32'd0);
        chk("rst.rs1", alu_rs1, 32'd0);
        chk("rst.wdata", rf_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        rf[1] = 32'd20; rf[2] = 32'd30;
        issue("add", W_ADD, 32'd20, 32'd30, 3'b000, 7'h00, 1'b1, 5'd3, 32'd50, 1'b0);

        rf[1] = 32'd8; rf[2] = 32'd3;
        issue("sub", W_SUB, 32'd8, 32'd3, 3'b000, 7'h20, 1'b1, 5'd5, 32'd5, 1'b0);

        rf[1] = 32'd1;
        issue("addi", W_ADDI, 32'd1, 32'hFFFF_FFFF, 3'b000, 7'h00, 1'b1, 5'd4, 32'd0, 1'b1);

        // Reset while the OR is in EXEC: everything clears, nothing retires.
        rf[1] = 32'd8; rf[2] = 32'd3;
        instr = W_OR9; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        chk("rstmid.pre_ready", 32'(instr_ready), 32'd0);
        chk("rstmid.pre_rs1", alu_rs1, 32'd8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid.ready", 32'(instr_ready), 32'd1);
        chk("rstmid.rs1", alu_rs1, 32'd0);
        chk("rstmid.rs2", alu_rs2, 32'd0);
        chk("rstmid.funct3", 32'(alu_funct3), 32'd0);
        chk("rstmid.we", 32'(rf_we), 32'd0);
        chk("rstmid.done", 32'(done), 32'd0);
        chk("rstmid.zero", 32'(zero), 32'd0);
        chk("rstmid.wdata", rf_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rstmid.post_we", 32'(rf_we), 32'd0);
            chk("rstmid.post_done", 32'(done), 32'd0);
            chk("rstmid.post_ready", 32'(instr_ready), 32'd1);
        end

        rf[1] = 32'h8000_0000;
        issue("srai", W_SRAI, 32'h8000_0000, 32'h0000_0403, 3'b101, 7'h20, 1'b1, 5'd6,
              32'hF000_0000, 1'b0);

        rf[1] = 32'd8; rf[2] = 32'd3;
        issue("xor_x0", W_XOR0, 32'd8, 32'd3, 3'b100, 7'h00, 1'b0, 5'd0, 32'd11, 1'b0);

        // Unsupported opcode: illegal pulse only.
        instr = W_LW; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        chk("ld.illegal", 32'(illegal), 32'd1);
        chk("ld.ready", 32'(instr_ready), 32'd1);
        chk("ld.we", 32'(rf_we), 32'd0);
        chk("ld.done", 32'(done), 32'd0);
        step();
        chk("ld.illegal_off", 32'(illegal), 32'd0);
        chk("ld.we2", 32'(rf_we), 32'd0);
        chk("ld.done2", 32'(done), 32'd0);

        // A second instruction held valid throughout waits for the post-WB idle cycle.
        rf[1] = 32'd8; rf[2] = 32'd3;
        instr = W_ADD; instr_valid = 1'b1;
        step();
        instr = W_SUB7;
        chk("b2b.exec_ready", 32'(instr_ready), 32'd0);
        chk("b2b.exec_f7", 32'(alu_funct7), 32'd0);
        step();
        chk("b2b.wb_waddr", 32'(rf_waddr), 32'd3);
        chk("b2b.wb_wdata", rf_wdata, 32'd11);
        chk("b2b.wb_ready", 32'(instr_ready), 32'd0);
        step();
        chk("b2b.idle_ready", 32'(instr_ready), 32'd1);
        chk("b2b.idle_f7", 32'(alu_funct7), 32'd0);
        chk("b2b.idle_done", 32'(done), 32'd0);
        step();
        instr_valid = 1'b0;
        chk("b2b.acc_ready", 32'(instr_ready), 32'd0);
        chk("b2b.acc_f7", 32'(alu_funct7), 32'h20);
        step();
        chk("b2b.wb2_done", 32'(done), 32'd1);
        chk("b2b.wb2_waddr", 32'(rf_waddr), 32'd7);
        chk("b2b.wb2_wdata", rf_wdata, 32'd5);
        step();
        chk("b2b.end_ready", 32'(instr_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
